// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in serial-out serializer.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width: max(1, clog2(width)), so WIDTH of 1 or 2 still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serializer_bit_counter.sv
// Bit-position counter for the serializer; flags the final bit of a word.
module serializer_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          increment,
    output logic [CW-1:0] cnt,
    output logic          is_last
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (increment) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign is_last = (cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: valid/ready word input, one bit per clock on ser_d
// with ser_en as the gate strobe for a downstream latch or flip-flop.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_d,
    output logic             ser_en,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned   CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             is_last;
    logic             handshake;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             out_bit;

    serializer_bit_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cnt_clear),
        .increment (cnt_inc),
        .cnt       (cnt),
        .is_last   (is_last)
    );

    assign out_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // in_ready never looks at in_valid; reset gates it low asynchronously.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        ser_d      = 1'b0;
        ser_en     = 1'b0;
        ser_last   = 1'b0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        in_ready   = rst_n && ((state == IDLE) || is_last);
        handshake  = in_valid && in_ready;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next = SHIFT;
                    cnt_clear  = 1'b1;
                end
            end
            SHIFT: begin
                ser_d    = out_bit;
                ser_en   = 1'b1;
                ser_last = is_last;
                if (is_last) begin
                    cnt_clear = 1'b1;
                    if (!handshake) begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = ser_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (handshake) begin
            sreg <= in_data;
        end else if (state == SHIFT) begin
            if (cnt != LAST) begin
                sreg <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            end else begin
                sreg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: three serializer configurations checked every cycle
// against a word/bit-position reference model.
module tb_piso_serializer;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_valid;
    logic [2:0] in_ready;
    logic [2:0] ser_d;
    logic [2:0] ser_en;
    logic [2:0] ser_last;
    logic [2:0] busy;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [0:0] d2;

    int checks = 0;
    int errors = 0;

    // Reference model: word in flight and index of the bit currently presented.
    int         w   [3] = '{8, 8, 1};
    int         msb [3] = '{1, 0, 1};
    bit         act [3];
    int         pos [3];
    logic [7:0] word[3];

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(d0), .ser_d(ser_d[0]), .ser_en(ser_en[0]), .ser_last(ser_last[0]),
        .busy(busy[0])
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(d1), .ser_d(ser_d[1]), .ser_en(ser_en[1]), .ser_last(ser_last[1]),
        .busy(busy[1])
    );

    piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(d2), .ser_d(ser_d[2]), .ser_en(ser_en[2]), .ser_last(ser_last[2]),
        .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic e_en, e_last, e_d, e_rdy;
        for (int i = 0; i < 3; i++) begin
            e_en   = act[i];
            e_last = act[i] && (pos[i] == w[i] - 1);
            e_d    = act[i] ? word[i][msb[i] != 0 ? w[i] - 1 - pos[i] : pos[i]] : 1'b0;
            e_rdy  = rst_n && (!act[i] || (pos[i] == w[i] - 1));
            chk($sformatf("u%0d.ser_en @%0t", i, $time),   ser_en[i],   e_en);
            chk($sformatf("u%0d.busy @%0t", i, $time),     busy[i],     e_en);
            chk($sformatf("u%0d.ser_last @%0t", i, $time), ser_last[i], e_last);
            chk($sformatf("u%0d.ser_d @%0t", i, $time),    ser_d[i],    e_d);
            chk($sformatf("u%0d.in_ready @%0t", i, $time), in_ready[i], e_rdy);
        end
    endtask

    // Check current outputs, advance one clock, update the model, return at negedge.
    task automatic cycle();
        bit         hs [3];
        logic [7:0] cap[3];
        check_all();
        cap[0] = d0;
        cap[1] = d1;
        cap[2] = {7'b0, d2};
        for (int i = 0; i < 3; i++)
            hs[i] = in_valid[i] && rst_n && (!act[i] || (pos[i] == w[i] - 1));
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (act[i]) begin
                if (pos[i] == w[i] - 1) act[i] = 1'b0;
                else pos[i] = pos[i] + 1;
            end
            if (hs[i]) begin
                act[i]  = 1'b1;
                pos[i]  = 0;
                word[i] = cap[i];
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            act[i] = 1'b0;
            pos[i] = 0;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 3'b111;
        d0 = 8'h3C; d1 = 8'hC3; d2 = 1'b1;
        clear_model();
        #1;
        repeat (3) cycle();

        rst_n    = 1'b1;
        in_valid = 3'b000;
        #1 check_all();

        // Single word MSB first: 8'hA5, input scrambled after capture
        in_valid[0] = 1'b1; d0 = 8'hA5;
        cycle();
        in_valid[0] = 1'b0;
        repeat (10) begin
            d0 = 8'($urandom);
            cycle();
        end

        // Back-to-back LSB first: 8'h01 then 8'h80 with valid held
        in_valid[1] = 1'b1; d1 = 8'h01;
        cycle();
        d1 = 8'h80;
        repeat (8) cycle();
        in_valid[1] = 1'b0;
        repeat (10) begin
            d1 = 8'($urandom);
            cycle();
        end

        // WIDTH=1 stream 1,0,1
        in_valid[2] = 1'b1;
        d2 = 1'b1; cycle();
        d2 = 1'b0; cycle();
        d2 = 1'b1; cycle();
        in_valid[2] = 1'b0;
        repeat (3) cycle();

        // Reset during the 4th bit of 8'hFF, then a clean 8'h0F
        in_valid[0] = 1'b1; d0 = 8'hFF;
        cycle();
        in_valid[0] = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b0;
        clear_model();
        #1 check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        #1 check_all();
        repeat (2) cycle();
        in_valid[0] = 1'b1; d0 = 8'h0F;
        cycle();
        in_valid[0] = 1'b0;
        repeat (10) cycle();

        // Random traffic with data changing every cycle
        repeat (400) begin
            in_valid = 3'($urandom);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            d2 = 1'($urandom);
            cycle();
        end
        in_valid = 3'b000;
        repeat (10) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out stage that feeds the single-bit level-sensitive storage elements of the latch/flip-flop family. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on `ser_d`. `ser_en` is the enable/gate strobe, so a downstream D latch or flip-flop can take `ser_d` directly on its data input. Back-to-back words stream with no idle gap.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is 1 or more.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: upstream word available.
- `in_ready`, output, 1: block can accept a word this cycle.
- `in_data`, input, WIDTH: word to serialize; sampled only on handshake.
- `ser_d`, output, 1: current serial bit.
- `ser_en`, output, 1: high on each cycle where `ser_d` carries a valid bit.
- `ser_last`, output, 1: high with the final bit of each word.
- `busy`, output, 1: word in flight; equals `ser_en`.

## Operation
- **States.**
  - IDLE: no word in flight.
  - SHIFT: word in flight.
  - The block holds a WIDTH-bit shift register and a bit counter `cnt` of width max(1, clog2(WIDTH)).
- **Handshake.** A handshake completes on a rising edge where `in_valid` and `in_ready` are both 1.
- **`in_ready` rule.**
  - `in_ready` = (state == IDLE) or (state == SHIFT and `cnt` == WIDTH-1).
  - `in_ready` is forced to 0 while `rst_n` is low.
- **IDLE, no handshake:** stay in IDLE.
- **IDLE, handshake:**
  - Load the shift register with `in_data`.
  - Set `cnt` = 0.
  - Go to SHIFT.
- **SHIFT, not the last bit (`cnt` < WIDTH-1):**
  - Shift the register toward the output end by one place.
  - Increment `cnt`.
- **SHIFT, last bit, handshake:**
  - Reload the shift register with the new word.
  - Set `cnt` = 0.
  - Stay in SHIFT.
- **SHIFT, last bit, no handshake:** go to IDLE.
- **Outputs.**
  - `ser_d` = the output-end bit of the shift register (MSB if `MSB_FIRST`, else LSB) while in SHIFT, and 0 in IDLE.
  - `ser_en` = `busy` = (state == SHIFT).
  - `ser_last` = (state == SHIFT and `cnt` == WIDTH-1).
- **Input hold.** `in_data` may change freely after the handshake. The block never re-samples it mid-word.
- **Withdrawn `in_valid`.** Upstream may drop `in_valid` without a handshake. The block tolerates this; nothing is captured.
- **WIDTH = 1.** Every SHIFT cycle is a last cycle. `ser_last` equals `ser_en`. `in_ready` is 1 in every cycle after reset.
- **Reset.**
  - Assertion of `rst_n`, including mid-word, immediately forces: state IDLE, shift register 0, `cnt` 0.
  - Output values during reset: `ser_d` 0, `ser_en` 0, `ser_last` 0, `busy` 0, `in_ready` 0.
  - After deassertion, `in_ready` becomes 1. A partially sent word is discarded and never resumed.

## Timing
- **Latency.** A handshake at edge N puts the first bit on `ser_d` with `ser_en` = 1 in the cycle after edge N. The word occupies exactly WIDTH consecutive cycles. `ser_last` is high in cycle WIDTH of the word.
- **Throughput.** With `in_valid` held high, 1 bit per clock and zero gap cycles between words.
- **Combinational paths.**
  - `ser_d`, `ser_en`, `ser_last` and `busy` are decoded only from registered state.
  - `in_ready` depends only on state, `cnt` and `rst_n`. It never depends on `in_valid`.
- **Downstream sampling.** A latch gated by `ser_en` sees `ser_d` stable for the whole high phase of each bit cycle.

## Structure
- **Package `piso_serializer_pkg`:**
  - state typedef: IDLE = 0, SHIFT = 1;
  - a function returning counter width max(1, clog2(WIDTH)).
- **Sub-module `serializer_bit_counter`:** one natural sub-module.
  - Parameterized by WIDTH.
  - Inputs: clear, increment.
  - Outputs: `cnt`, and `is_last` (`cnt` == WIDTH-1).
  - Reset is asynchronous active-low on `rst_n`.
- **Top level:** holds the FSM, the shift register and the output decode.

## Test plan
- **Reset values:** hold `rst_n` = 0 for 3 cycles with `in_valid` = 1 -> all outputs 0, including `in_ready`. After release, `in_ready` = 1 and `ser_en` = 0.
- **Single word, MSB first:** WIDTH=8, `MSB_FIRST`=1, send 8'hA5 -> over 8 cycles `ser_d` = 1,0,1,0,0,1,0,1; `ser_en` = 1 throughout; `ser_last` only on the 8th bit; then IDLE with `ser_d` 0.
- **Back-to-back, LSB first:** `MSB_FIRST`=0, send 8'h01 then 8'h80 with `in_valid` held -> 16 contiguous `ser_en` cycles reading 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1. The second handshake lands on the first word's `ser_last` cycle.
- **Input change after handshake:** change `in_data` every cycle after the handshake -> the serial output still equals the originally captured word.
- **Reset mid-word:** pulse `rst_n` low during the 4th bit of 8'hFF -> outputs drop to 0 asynchronously. After release, no residual bits appear, and a new 8'h0F serializes cleanly.
- **WIDTH=1:** stream bits 1,0,1 -> `ser_en` and `ser_last` both high for 3 contiguous cycles, `ser_d` = 1,0,1, `in_ready` constantly 1.
